// File: rtl/stream_exec_sequencer.sv
// Run sequencer for the multi-stream buffer bank: holds per-stream address
// windows, streams host words into every window, pulses reset-execution,
// runs execution until all streams report done, then signals completion.
module stream_exec_sequencer #(
  parameter int unsigned N_STREAMS     = 8,
  parameter int unsigned STREAM_ADDR_L = 10,
  parameter int unsigned STREAM_W      = 24,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_wr,
  input  logic [$clog2(N_STREAMS)-1:0]       cfg_stream_id,
  input  logic [STREAM_ADDR_L-1:0]           cfg_start_addr,
  input  logic [STREAM_ADDR_L-1:0]           cfg_end_addr,
  output logic                               cfg_err,
  input  logic                               start,
  input  logic                               abort,
  input  logic [STREAM_W-1:0]                ld_data,
  input  logic                               ld_vld,
  output logic                               ld_rdy,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_W-1:0]                   exec_cycles,
  output logic [STREAM_W-1:0]                wr_data_io,
  output logic [STREAM_ADDR_L-1:0]           addr_io,
  output logic [$clog2(N_STREAMS)-1:0]       stream_id_io,
  output logic                               wr_vld_io,
  output logic                               reset_execution_io,
  output logic                               enable_execution_io,
  input  logic                               done_execution_io,
  output logic [N_STREAMS*STREAM_ADDR_L-1:0] stream_start_addr_io,
  output logic [N_STREAMS*STREAM_ADDR_L-1:0] stream_end_addr_io
);

  localparam int unsigned AW    = STREAM_ADDR_L;
  localparam int unsigned SID_W = $clog2(N_STREAMS);

  localparam logic [AW-1:0]    ADDR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SID_W-1:0] LAST_SID = SID_W'(N_STREAMS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RST_EXEC = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SID_W-1:0]       cur_stream_q, cur_stream_d;
  logic [AW-1:0]          cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]       exec_cycles_q, exec_cycles_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [N_STREAMS-1:0]   cfg_valid_q, cfg_valid_d;
  logic [AW-1:0]          win_start_q [N_STREAMS];
  logic [AW-1:0]          win_start_d [N_STREAMS];
  logic [AW-1:0]          win_end_q   [N_STREAMS];
  logic [AW-1:0]          win_end_d   [N_STREAMS];
  logic [SID_W-1:0]       nxt_sid;

  assign cfg_err     = cfg_err_q;
  assign exec_cycles = exec_cycles_q;

  // Expose the configured windows to the stream bank as flat vectors.
  for (genvar g = 0; g < N_STREAMS; g++) begin : g_win
    assign stream_start_addr_io[g*AW +: AW] = win_start_q[g];
    assign stream_end_addr_io[g*AW +: AW]   = win_end_q[g];
  end

  // Next-state, config update and stream-bank control decode.
  always_comb begin
    state_d             = state_q;
    cur_stream_d        = cur_stream_q;
    cur_addr_d          = cur_addr_q;
    exec_cycles_d       = exec_cycles_q;
    cfg_err_d           = 1'b0;
    cfg_valid_d         = cfg_valid_q;
    win_start_d         = win_start_q;
    win_end_d           = win_end_q;
    nxt_sid             = cur_stream_q + SID_W'(1);
    ld_rdy              = 1'b0;
    wr_vld_io           = 1'b0;
    wr_data_io          = '0;
    addr_io             = '0;
    stream_id_io        = '0;
    reset_execution_io  = 1'b0;
    enable_execution_io = 1'b0;
    done                = 1'b0;
    busy                = (state_q != S_IDLE);

    // An end address of all-ones would make the bank's end+1 compare wrap.
    if (cfg_wr) begin
      if ((state_q != S_IDLE) || (cfg_start_addr > cfg_end_addr) ||
          (cfg_end_addr == ADDR_MAX)) begin
        cfg_err_d = 1'b1;
      end else begin
        win_start_d[cfg_stream_id] = cfg_start_addr;
        win_end_d[cfg_stream_id]   = cfg_end_addr;
        cfg_valid_d[cfg_stream_id] = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (&cfg_valid_q) begin
            state_d      = S_LOAD;
            cur_stream_d = '0;
            cur_addr_d   = win_start_q[0];
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ld_rdy       = 1'b1;
        wr_vld_io    = ld_vld;
        wr_data_io   = ld_data;
        addr_io      = cur_addr_q;
        stream_id_io = cur_stream_q;
        if (ld_vld) begin
          if (cur_addr_q == win_end_q[cur_stream_q]) begin
            if (cur_stream_q == LAST_SID) begin
              state_d = S_RST_EXEC;
            end else begin
              cur_stream_d = nxt_sid;
              cur_addr_d   = win_start_q[nxt_sid];
            end
          end else begin
            cur_addr_d = cur_addr_q + AW'(1);
          end
        end
      end
      S_RST_EXEC: begin
        reset_execution_io = 1'b1;
        exec_cycles_d      = '0;
        state_d            = S_RUN;
      end
      S_RUN: begin
        enable_execution_io = 1'b1;
        if (exec_cycles_q != CNT_MAX) begin
          exec_cycles_d = exec_cycles_q + CNT_W'(1);
        end
        if (done_execution_io) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cur_stream_q  <= '0;
      cur_addr_q    <= '0;
      exec_cycles_q <= '0;
      cfg_err_q     <= 1'b0;
      cfg_valid_q   <= '0;
      win_start_q   <= '{default: '0};
      win_end_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cur_stream_q  <= cur_stream_d;
      cur_addr_q    <= cur_addr_d;
      exec_cycles_q <= exec_cycles_d;
      cfg_err_q     <= cfg_err_d;
      cfg_valid_q   <= cfg_valid_d;
      win_start_q   <= win_start_d;
      win_end_q     <= win_end_d;
    end
  end

endmodule

// File: tb/tb_stream_exec_sequencer.sv
// Scoreboard bench for stream_exec_sequencer: a window-level model predicts
// every bank write and every completion count; a monitor checks them.
module tb_stream_exec_sequencer;

  localparam int unsigned NS = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int          CNT_SAT = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic              cfg_stream_id;
  logic [AW-1:0]     cfg_start_addr;
  logic [AW-1:0]     cfg_end_addr;
  logic              cfg_err;
  logic              start;
  logic              abort;
  logic [DW-1:0]     ld_data;
  logic              ld_vld;
  logic              ld_rdy;
  logic              busy;
  logic              done;
  logic [CW-1:0]     exec_cycles;
  logic [DW-1:0]     wr_data_io;
  logic [AW-1:0]     addr_io;
  logic              stream_id_io;
  logic              wr_vld_io;
  logic              reset_execution_io;
  logic              enable_execution_io;
  logic              done_execution_io;
  logic [NS*AW-1:0]  stream_start_addr_io;
  logic [NS*AW-1:0]  stream_end_addr_io;

  stream_exec_sequencer #(
    .N_STREAMS(NS), .STREAM_ADDR_L(AW), .STREAM_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_stream_id(cfg_stream_id),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_err(cfg_err), .start(start), .abort(abort),
    .ld_data(ld_data), .ld_vld(ld_vld), .ld_rdy(ld_rdy),
    .busy(busy), .done(done), .exec_cycles(exec_cycles),
    .wr_data_io(wr_data_io), .addr_io(addr_io), .stream_id_io(stream_id_io),
    .wr_vld_io(wr_vld_io), .reset_execution_io(reset_execution_io),
    .enable_execution_io(enable_execution_io),
    .done_execution_io(done_execution_io),
    .stream_start_addr_io(stream_start_addr_io),
    .stream_end_addr_io(stream_end_addr_io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  wr_t cur_list[$];

  int m_start[NS];
  int m_end[NS];
  bit m_valid[NS];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS*AW-1:0] flat_win(input bit ends);
    logic [NS*AW-1:0] r;
    r = '0;
    for (int s = 0; s < int'(NS); s++) r[s*AW +: AW] = AW'(ends ? m_end[s] : m_start[s]);
    return r;
  endfunction

  function automatic bit all_valid();
    bit r;
    r = 1'b1;
    for (int s = 0; s < int'(NS); s++) r &= m_valid[s];
    return r;
  endfunction

  function automatic int sat_cnt(input int n);
    return (n > CNT_SAT) ? CNT_SAT : n;
  endfunction

  // Expected bank writes for one full load, stream by stream through each window.
  task automatic build_list(input int mode);
    logic [DW-1:0] d;
    cur_list.delete();
    for (int s = 0; s < int'(NS); s++)
      for (int a = m_start[s]; a <= m_end[s]; a++) begin
        d = (mode == 0) ? DW'(8'h0A + cur_list.size()) : DW'($urandom);
        cur_list.push_back('{sid: 1'(s), addr: AW'(a), data: d});
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ld_rdy"}, 32'(ld_rdy), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_wr_vld"}, 32'(wr_vld_io), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data_io), 32'd0);
    check({tag, "_addr"}, 32'(addr_io), 32'd0);
    check({tag, "_sid"}, 32'(stream_id_io), 32'd0);
    check({tag, "_rst_exec"}, 32'(reset_execution_io), 32'd0);
    check({tag, "_enable"}, 32'(enable_execution_io), 32'd0);
    check({tag, "_exec_cycles"}, 32'(exec_cycles), 32'd0);
    check({tag, "_win_start"}, 32'(stream_start_addr_io), 32'd0);
    check({tag, "_win_end"}, 32'(stream_end_addr_io), 32'd0);
  endtask

  task automatic cfg_write(input int id, input int s, input int e);
    bit exp_err;
    exp_err = (s > e) || (e == (1 << AW) - 1);
    cfg_wr = 1'b1; cfg_stream_id = 1'(id);
    cfg_start_addr = AW'(s); cfg_end_addr = AW'(e);
    tick();
    cfg_wr = 1'b0;
    @(negedge clk);
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (!exp_err) begin
      m_start[id] = s; m_end[id] = e; m_valid[id] = 1'b1;
    end
    check("win_start", 32'(stream_start_addr_io), 32'(flat_win(1'b0)));
    check("win_end", 32'(stream_end_addr_io), 32'(flat_win(1'b1)));
    tick();
  endtask

  task automatic start_reject();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_rej_err", 32'(cfg_err), 32'(!all_valid()));
    check("start_rej_busy", 32'(busy), 32'd0);
    tick();
  endtask

  // mode 0: ld_vld held high with data 0xA.., 1: random vld/data, 2: vld pattern 1,0,0,1,1
  task automatic run(input int mode, input int done_at, input int abort_at, input bit busy_tests);
    int pat[5] = '{1, 0, 0, 1, 1};
    int total, k, cyc, exp_cnt;
    bit v, acc;
    build_list(mode);
    total = cur_list.size();
    foreach (cur_list[i]) exp_wr.push_back(cur_list[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < total && cyc < 400) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 2) v = (cyc < 5) ? (pat[cyc] != 0) : 1'b1;
      else v = ($urandom_range(0, 2) != 0);
      ld_vld = v;
      ld_data = v ? cur_list[k].data : DW'($urandom);
      @(negedge clk);
      acc = ld_vld && ld_rdy;
      if (cyc == 0) begin
        check("load_busy", 32'(busy), 32'd1);
        check("load_rdy", 32'(ld_rdy), 32'd1);
      end
      if (!v) begin
        check("gap_no_wr", 32'(wr_vld_io), 32'd0);
        if (exp_wr.size() > 0) check("gap_addr_hold", 32'(addr_io), 32'(exp_wr[0].addr));
      end
      tick();
      cyc++;
      if (acc) k++;
    end
    ld_vld = 1'b0;
    if (k < total) check("load_timeout", 32'(k), 32'(total));
    @(negedge clk);
    check("rst_exec_high", 32'(reset_execution_io), 32'd1);
    check("rst_exec_enable_low", 32'(enable_execution_io), 32'd0);
    tick();
    for (int c = 1; c <= 64; c++) begin
      done_execution_io = (c == done_at);
      abort = (c == abort_at);
      if (busy_tests && c == 1) begin
        cfg_wr = 1'b1; cfg_stream_id = 1'b0; cfg_start_addr = AW'(0); cfg_end_addr = AW'(1);
      end
      if (busy_tests && c == 3) start = 1'b1;
      if (c == done_at) exp_done.push_back(sat_cnt(done_at));
      @(negedge clk);
      check("run_enable", 32'(enable_execution_io), 32'd1);
      if (c == 1) check("rst_exec_one_cycle", 32'(reset_execution_io), 32'd0);
      if (busy_tests && c == 2) check("cfg_busy_err", 32'(cfg_err), 32'd1);
      if (busy_tests && c == 4) check("start_busy_no_err", 32'(cfg_err), 32'd0);
      tick();
      done_execution_io = 1'b0; abort = 1'b0; cfg_wr = 1'b0; start = 1'b0;
      if (c == done_at || c == abort_at) break;
      if (c == 64) check("run_budget", 32'(c), 32'd0);
    end
    if (busy_tests) check("win_start_kept", 32'(stream_start_addr_io), 32'(flat_win(1'b0)));
    if (abort_at != 0) begin
      exp_cnt = sat_cnt(abort_at);
      @(negedge clk);
      check("abort_enable_low", 32'(enable_execution_io), 32'd0);
      check("abort_busy_low", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_exec_cycles", 32'(exec_cycles), 32'(exp_cnt));
      tick();
    end else begin
      exp_cnt = sat_cnt(done_at);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_enable_low", 32'(enable_execution_io), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check("after_done_busy", 32'(busy), 32'd0);
      check("after_done_pulse_end", 32'(done), 32'd0);
      check("after_done_exec_cycles", 32'(exec_cycles), 32'(exp_cnt));
      tick();
    end
  endtask

  // Monitor: every bank write and every completion is matched against the scoreboard.
  always @(negedge clk) begin : mon
    wr_t got;
    wr_t want;
    int  cnt;
    if (rst === 1'b1 && wr_vld_io === 1'b1) begin
      got = '{sid: stream_id_io, addr: addr_io, data: wr_data_io};
      if (exp_wr.size() == 0) check("unexpected_wr", 32'(got), 32'hFFFF_FFFF);
      else begin
        want = exp_wr.pop_front();
        check("wr_beat", 32'(got), 32'(want));
      end
    end
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_done.size() == 0) check("unexpected_done", 32'(exec_cycles), 32'hFFFF_FFFF);
      else begin
        cnt = exp_done.pop_front();
        check("done_exec_cycles", 32'(exec_cycles), 32'(cnt));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b0; cfg_wr = 1'b0; cfg_stream_id = 1'b0;
    cfg_start_addr = '0; cfg_end_addr = '0; start = 1'b0; abort = 1'b0;
    ld_data = 8'h5A; ld_vld = 1'b0; done_execution_io = 1'b0;
    for (int s = 0; s < int'(NS); s++) begin
      m_start[s] = 0; m_end[s] = 0; m_valid[s] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    start_reject();
    cfg_write(0, 2, 4);
    cfg_write(1, 0, 1);
    run(0, 7, 0, 1'b1);

    cfg_write(0, 2, 15);
    cfg_write(1, 5, 3);
    run(2, 3, 0, 1'b0);
    run(1, 0, 3, 1'b0);

    cfg_write(0, 14, 14);
    cfg_write(1, 0, 0);
    run(1, 20, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      cfg_write($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
      cfg_write($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
      run(1, $urandom_range(1, 10), 0, 1'b0);
    end

    // Asynchronous reset in the middle of a load.
    cfg_write(0, 3, 7);
    cfg_write(1, 8, 9);
    build_list(1);
    exp_wr.push_back(cur_list[0]);
    exp_wr.push_back(cur_list[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_vld = 1'b1; ld_data = cur_list[0].data;
    tick();
    ld_data = cur_list[1].data;
    tick();
    ld_vld = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_load_rst");
    exp_wr.delete();
    for (int s = 0; s < int'(NS); s++) begin
      m_start[s] = 0; m_end[s] = 0; m_valid[s] = 1'b0;
    end
    tick();
    rst = 1'b1;
    tick();
    start_reject();

    repeat (2) tick();
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
